// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART APB sequencer: FSM state codes,
// UART register offsets and status bit positions.
package uart_apb_pkg;

   // FSM state codes; every state except GAP owns exactly one APB transfer
   typedef logic [2:0] state_t;
   localparam state_t ST_INIT_CTRL = 3'd0;
   localparam state_t ST_INIT_SCLR = 3'd1;
   localparam state_t ST_POLL      = 3'd2;
   localparam state_t ST_RX_RD     = 3'd3;
   localparam state_t ST_TX_WR     = 3'd4;
   localparam state_t ST_GAP       = 3'd5;

   // UART register byte offsets inside the register window
   localparam logic [31:0] OFF_DATA   = 32'h0000_0000;
   localparam logic [31:0] OFF_STATUS = 32'h0000_0004;
   localparam logic [31:0] OFF_CTRL   = 32'h0000_0008;
   localparam logic [31:0] OFF_SCALER = 32'h0000_000C;

   // Status register bit indices
   localparam int STAT_DR = 0;   // receive data ready
   localparam int STAT_TS = 1;   // transmitter shift register empty
   localparam int STAT_TE = 2;   // transmitter FIFO empty
   localparam int STAT_TF = 9;   // transmitter FIFO full
   localparam int STAT_RF = 10;  // receiver FIFO full

   // True for states that perform an APB transfer
   function automatic logic is_xfer_state(input state_t s);
      return (s != ST_GAP);
   endfunction

endpackage

// File: rtl/uart_apb_sequencer_if.sv
// APB bus between the sequencer (master) and the UART wrapper (slave).
interface uart_apb_sequencer_if;
   logic        psel;
   logic        penable;
   logic [31:0] paddr;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      output psel, penable, paddr, pwrite, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, paddr, pwrite, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_master_port.sv
// Single-transfer APB engine. A start request is taken whenever the bus
// is idle or the current transfer is completing, so back-to-back
// transfers run with no idle cycle. done/rdata/slverr are valid in the
// last ACCESS cycle of a transfer.
module apb_master_port (
   input  logic        clk,
   input  logic        rstn,
   input  logic        start,
   input  logic [31:0] addr,
   input  logic        write,
   input  logic [31:0] wdata,
   output logic        done,
   output logic        busy,
   output logic [31:0] rdata,
   output logic        slverr,
   uart_apb_sequencer_if.master apb
);

   assign done   = apb.psel && apb.penable && apb.pready;
   assign busy   = apb.psel;
   assign rdata  = apb.prdata;
   assign slverr = apb.pslverr;

   // SETUP on a taken start, ACCESS afterwards, hold ACCESS until pready
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         apb.psel    <= 1'b0;
         apb.penable <= 1'b0;
         apb.paddr   <= 32'h0;
         apb.pwrite  <= 1'b0;
         apb.pwdata  <= 32'h0;
      end else if (!apb.psel || done) begin
         if (start) begin
            apb.psel    <= 1'b1;
            apb.penable <= 1'b0;
            apb.paddr   <= addr;
            apb.pwrite  <= write;
            apb.pwdata  <= wdata;
         end else begin
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
         end
      end else begin
         apb.penable <= 1'b1;
      end
   end

endmodule

// File: rtl/uart_apb_sequencer.sv
// Hardware APB master for apbuart_wrapper: programs control and scaler
// once after reset, then polls status and moves bytes between two
// one-entry valid/ready registers and the UART data register.
module uart_apb_sequencer
   import uart_apb_pkg::*;
#(
   parameter logic [31:0] PADDR_BASE  = 32'h0,
   parameter logic [31:0] CTRL_INIT   = 32'h3,
   parameter logic [31:0] SCALER_INIT = 32'd650,
   parameter int          POLL_GAP    = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       init_done,
   output logic       err,
   uart_apb_sequencer_if.master apb
);

   localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

   state_t            state_reg;
   state_t            state_next;
   logic [GAP_W-1:0]  gap_cnt_reg;
   logic              held_reg;
   logic [7:0]        tx_byte_reg;

   logic              start;
   logic [31:0]       xfer_addr;
   logic              xfer_write;
   logic [31:0]       xfer_wdata;
   logic              done;
   logic              busy;
   logic [31:0]       rdata;
   logic              slverr;

   // Only DR, TF and the data byte are consumed from read data
   logic              unused_rdata;
   assign unused_rdata = ^{rdata[31:10], rdata[8]};

   assign tx_ready = !held_reg && init_done;

   apb_master_port u_port (
      .clk    (clk),
      .rstn   (rstn),
      .start  (start),
      .addr   (xfer_addr),
      .write  (xfer_write),
      .wdata  (xfer_wdata),
      .done   (done),
      .busy   (busy),
      .rdata  (rdata),
      .slverr (slverr),
      .apb    (apb)
   );

   // Next state; RX has priority over TX after each status read
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_INIT_CTRL: if (done) state_next = ST_INIT_SCLR;
         ST_INIT_SCLR: if (done) state_next = ST_POLL;
         ST_POLL: begin
            if (done) begin
               if (rdata[STAT_DR] && !rx_valid)
                  state_next = ST_RX_RD;
               else if (held_reg && !rdata[STAT_TF])
                  state_next = ST_TX_WR;
               else if (POLL_GAP == 0)
                  state_next = ST_POLL;
               else
                  state_next = ST_GAP;
            end
         end
         ST_RX_RD:     if (done) state_next = ST_POLL;
         ST_TX_WR:     if (done) state_next = ST_POLL;
         ST_GAP:       if (gap_cnt_reg == GAP_LAST) state_next = ST_POLL;
         default:      state_next = ST_INIT_CTRL;
      endcase
   end

   // Launch the next state's transfer while the bus is free or finishing
   always_comb begin
      start      = is_xfer_state(state_next) && (done || !busy);
      xfer_addr  = PADDR_BASE + OFF_STATUS;
      xfer_write = 1'b0;
      xfer_wdata = 32'h0;
      case (state_next)
         ST_INIT_CTRL: begin
            xfer_addr  = PADDR_BASE + OFF_CTRL;
            xfer_write = 1'b1;
            xfer_wdata = CTRL_INIT;
         end
         ST_INIT_SCLR: begin
            xfer_addr  = PADDR_BASE + OFF_SCALER;
            xfer_write = 1'b1;
            xfer_wdata = SCALER_INIT;
         end
         ST_RX_RD: begin
            xfer_addr  = PADDR_BASE + OFF_DATA;
         end
         ST_TX_WR: begin
            xfer_addr  = PADDR_BASE + OFF_DATA;
            xfer_write = 1'b1;
            xfer_wdata = {24'h0, tx_byte_reg};
         end
         default: ;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_reg <= ST_INIT_CTRL;
      else       state_reg <= state_next;
   end

   // Idle-cycle counter, running only while in GAP
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                  gap_cnt_reg <= '0;
      else if (state_reg == ST_GAP) gap_cnt_reg <= gap_cnt_reg + 1'b1;
      else                        gap_cnt_reg <= '0;
   end

   // Init-complete flag and sticky slave-error flag
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         init_done <= 1'b0;
         err       <= 1'b0;
      end else begin
         if (done && state_reg == ST_INIT_SCLR) init_done <= 1'b1;
         if (done && slverr)                    err       <= 1'b1;
      end
   end

   // TX holding register; a finished (or errored) write always empties it
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         held_reg    <= 1'b0;
         tx_byte_reg <= 8'h0;
      end else if (done && state_reg == ST_TX_WR) begin
         held_reg    <= 1'b0;
      end else if (tx_valid && tx_ready) begin
         held_reg    <= 1'b1;
         tx_byte_reg <= tx_data;
      end
   end

   // RX output register; a completing data read wins over a consumer clear
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_valid <= 1'b0;
         rx_data  <= 8'h0;
      end else if (done && state_reg == ST_RX_RD) begin
         rx_valid <= 1'b1;
         rx_data  <= rdata[7:0];
      end else if (rx_valid && rx_ready) begin
         rx_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_apb_sequencer.sv
// Directed bench for uart_apb_sequencer: the bench plays the UART APB
// slave one transfer at a time; expected transfers and received bytes are
// queued when stimulus is issued and checked when the DUT produces them.
module tb_uart_apb_sequencer;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
   } xfer_t;

   logic       clk;
   logic       rstn;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       init_done;
   logic       err;

   uart_apb_sequencer_if apb_bus ();

   uart_apb_sequencer dut (
      .clk       (clk),
      .rstn      (rstn),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .init_done (init_done),
      .err       (err),
      .apb       (apb_bus)
   );

   int n_cmp = 0;
   int n_mis = 0;
   xfer_t      exp_q[$];
   logic [7:0] rx_q[$];
   logic [7:0] tx_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Serve one APB transfer: check its setup, hold ACCESS for stretch
   // extra cycles, return rd/se, end on the negedge after completion.
   task automatic serve(input string tag, input logic [31:0] ea, input logic ew,
                        input logic [31:0] ewd, input logic [31:0] rd, input logic se,
                        input int stretch, output int waited);
      xfer_t e;
      int pen_cnt;
      exp_q.push_back('{addr: ea, write: ew, wdata: ewd});
      waited = 0;
      while (!apb_bus.psel && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!apb_bus.psel) begin
         chk({tag, ".timeout"}, 32'(apb_bus.psel), 32'd1);
         return;
      end
      e = exp_q.pop_front();
      chk({tag, ".addr"}, apb_bus.paddr, e.addr);
      chk({tag, ".write"}, 32'(apb_bus.pwrite), 32'(e.write));
      if (e.write) chk({tag, ".wdata"}, apb_bus.pwdata, e.wdata);
      pen_cnt = 0;
      for (int k = 0; k <= stretch; k++) begin
         @(negedge clk);
         if (apb_bus.psel && apb_bus.penable) pen_cnt++;
         apb_bus.pready  = (k == stretch);
         apb_bus.prdata  = rd;
         apb_bus.pslverr = se;
      end
      chk({tag, ".access_cycles"}, 32'(pen_cnt), 32'(stretch + 1));
      @(negedge clk);
      apb_bus.pready  = 1'b0;
      apb_bus.pslverr = 1'b0;
      apb_bus.prdata  = 32'h0;
   endtask

   task automatic send_tx(input logic [7:0] b);
      int n;
      n = 0;
      while (!tx_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("tx_ready_wait", 32'(tx_ready), 32'd1);
      tx_data  = b;
      tx_valid = 1'b1;
      tx_q.push_back(b);
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic take_rx(input string tag);
      int n;
      logic [7:0] e;
      n = 0;
      while (!rx_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({tag, ".rx_valid"}, 32'(rx_valid), 32'd1);
      e = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
      chk({tag, ".rx_data"}, 32'(rx_data), 32'(e));
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      chk({tag, ".rx_clear"}, 32'(rx_valid), 32'd0);
   endtask

   initial begin
      int w;
      rstn            = 1'b0;
      tx_data         = 8'h0;
      tx_valid        = 1'b0;
      rx_ready        = 1'b0;
      apb_bus.prdata  = 32'h0;
      apb_bus.pready  = 1'b0;
      apb_bus.pslverr = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst.bus", {apb_bus.psel, apb_bus.penable, apb_bus.pwrite}, 32'd0);
      chk("rst.paddr", apb_bus.paddr, 32'h0);
      chk("rst.pwdata", apb_bus.pwdata, 32'h0);
      chk("rst.flags", {tx_ready, rx_valid, init_done, err}, 32'd0);
      chk("rst.rx_data", 32'(rx_data), 32'h0);
      rstn = 1'b1;

      // 1: init writes, then status read with no idle cycle between
      serve("init_ctrl", 32'h08, 1'b1, 32'h3, 32'h0, 1'b0, 0, w);
      chk("init_ctrl.not_done", 32'(init_done), 32'd0);
      serve("init_sclr", 32'h0C, 1'b1, 32'd650, 32'h0, 1'b0, 0, w);
      chk("init_sclr.no_idle", 32'(w), 32'd0);
      chk("init_done", 32'(init_done), 32'd1);
      chk("init.tx_ready", 32'(tx_ready), 32'd1);
      serve("poll0", 32'h04, 1'b0, 32'h0, 32'h0, 1'b0, 0, w);
      chk("poll0.no_idle", 32'(w), 32'd0);
      serve("poll1", 32'h04, 1'b0, 32'h0, 32'h0, 1'b0, 0, w);
      chk("poll1.gap", 32'(w), 32'd4);

      // 2: single TX byte
      send_tx(8'h2A);
      chk("tx2a.held", 32'(tx_ready), 32'd0);
      serve("poll2", 32'h04, 1'b0, 32'h0, 32'h0, 1'b0, 0, w);
      serve("tx2a", 32'h00, 1'b1, {24'h0, tx_q.pop_front()}, 32'h0, 1'b0, 0, w);
      chk("tx2a.no_idle", 32'(w), 32'd0);
      chk("tx2a.ready_back", 32'(tx_ready), 32'd1);

      // 3: TX FIFO full holds the byte back
      send_tx(8'h5C);
      serve("poll_tf0", 32'h04, 1'b0, 32'h0, 32'h200, 1'b0, 0, w);
      serve("poll_tf1", 32'h04, 1'b0, 32'h0, 32'h200, 1'b0, 0, w);
      chk("tf.still_held", 32'(tx_ready), 32'd0);
      serve("poll_tf2", 32'h04, 1'b0, 32'h0, 32'h0, 1'b0, 0, w);
      serve("tx5c", 32'h00, 1'b1, {24'h0, tx_q.pop_front()}, 32'h0, 1'b0, 0, w);
      serve("poll3", 32'h04, 1'b0, 32'h0, 32'h0, 1'b0, 0, w);

      // 4: RX with consumer backpressure
      serve("poll_dr0", 32'h04, 1'b0, 32'h0, 32'h1, 1'b0, 0, w);
      rx_q.push_back(8'hD5);
      serve("rxd5", 32'h00, 1'b0, 32'h0, 32'hD5, 1'b0, 0, w);
      chk("rxd5.valid", 32'(rx_valid), 32'd1);
      chk("rxd5.data", 32'(rx_data), 32'hD5);
      serve("poll_bp0", 32'h04, 1'b0, 32'h0, 32'h1, 1'b0, 0, w);
      serve("poll_bp1", 32'h04, 1'b0, 32'h0, 32'h1, 1'b0, 0, w);
      chk("poll_bp1.gap", 32'(w), 32'd4);
      chk("rxd5.held", 32'(rx_valid), 32'd1);
      take_rx("rxd5");
      serve("poll_dr1", 32'h04, 1'b0, 32'h0, 32'h1, 1'b0, 0, w);
      rx_q.push_back(8'h3C);
      serve("rx3c", 32'h00, 1'b0, 32'h0, 32'h3C, 1'b0, 0, w);
      take_rx("rx3c");

      // 5: RX before TX, with a stretched access phase
      send_tx(8'h77);
      serve("poll_both", 32'h04, 1'b0, 32'h0, 32'h1, 1'b0, 0, w);
      rx_q.push_back(8'h91);
      serve("rx91", 32'h00, 1'b0, 32'h0, 32'h91, 1'b0, 2, w);
      serve("poll_both2", 32'h04, 1'b0, 32'h0, 32'h1, 1'b0, 0, w);
      serve("tx77", 32'h00, 1'b1, {24'h0, tx_q.pop_front()}, 32'h0, 1'b0, 0, w);
      take_rx("rx91");
      chk("tx77.ready_back", 32'(tx_ready), 32'd1);

      // Slave errors on data accesses: no retry, byte still delivered
      send_tx(8'h42);
      serve("poll_e0", 32'h04, 1'b0, 32'h0, 32'h0, 1'b0, 0, w);
      chk("pre_err", 32'(err), 32'd0);
      serve("tx42_err", 32'h00, 1'b1, {24'h0, tx_q.pop_front()}, 32'h0, 1'b1, 0, w);
      chk("tx42_err.err", 32'(err), 32'd1);
      chk("tx42_err.dropped", 32'(tx_ready), 32'd1);
      serve("poll_e1", 32'h04, 1'b0, 32'h0, 32'h1, 1'b0, 0, w);
      rx_q.push_back(8'hE7);
      serve("rxe7_err", 32'h00, 1'b0, 32'h0, 32'hE7, 1'b1, 0, w);
      take_rx("rxe7_err");

      // 6: reset in the middle of a TX write
      send_tx(8'h99);
      serve("poll_r0", 32'h04, 1'b0, 32'h0, 32'h0, 1'b0, 0, w);
      w = 0;
      while (!apb_bus.psel && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("txrst.psel", 32'(apb_bus.psel), 32'd1);
      chk("txrst.addr", apb_bus.paddr, 32'h0);
      chk("txrst.wdata", apb_bus.pwdata, 32'h99);
      void'(tx_q.pop_front());
      rstn = 1'b0;
      #1;
      chk("txrst.bus_drop", {apb_bus.psel, apb_bus.penable}, 32'd0);
      chk("txrst.flags", {tx_ready, rx_valid, init_done, err}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      serve("re_ctrl", 32'h08, 1'b1, 32'h3, 32'h0, 1'b0, 0, w);
      chk("re_ctrl.err", 32'(err), 32'd0);
      serve("re_sclr_err", 32'h0C, 1'b1, 32'd650, 32'h0, 1'b1, 0, w);
      chk("re_sclr.err", 32'(err), 32'd1);
      chk("re_sclr.init_done", 32'(init_done), 32'd1);
      serve("re_poll0", 32'h04, 1'b0, 32'h0, 32'h0, 1'b0, 0, w);
      serve("re_poll1", 32'h04, 1'b0, 32'h0, 32'h0, 1'b0, 0, w);
      chk("re_poll1.gap", 32'(w), 32'd4);
      chk("err.sticky", 32'(err), 32'd1);

      chk("exp_q.empty", 32'(exp_q.size()), 32'd0);
      chk("rx_q.empty", 32'(rx_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
